// File: rtl/core_byte_sequencer.sv
// Byte-serial front end for the single-cycle RV32 core: assembles a 32-bit instruction,
// issues one core_step, captures the ALU result and drains it LSB first over valid/ready.
module core_byte_sequencer #(
    parameter int OUT_BYTES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             halt,
    output logic [31:0]      instr,
    output logic             core_step,
    input  logic [31:0]      alu_result,
    output logic [7:0]       result_byte,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] LAST_DRAIN = 2'(OUT_BYTES - 1);

    state_t           state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [1:0]       drain_idx_q, drain_idx_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      buf_q, buf_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic byte_acc;
    logic res_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            byte_idx_q  <= 2'd0;
            drain_idx_q <= 2'd0;
            instr_q     <= 32'd0;
            buf_q       <= 32'd0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            drain_idx_q <= drain_idx_d;
            instr_q     <= instr_d;
            buf_q       <= buf_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (byte_acc && byte_idx_q == 2'd3)            state_d = ST_EXEC;
            ST_EXEC:  if (!halt)                                    state_d = ST_DRAIN;
            ST_DRAIN: if (res_acc && drain_idx_q == LAST_DRAIN)     state_d = ST_LOAD;
            default:                                                state_d = ST_LOAD;
        endcase
    end

    // Handshake strobes depend only on state (and halt); reset masks them immediately.
    always_comb begin
        byte_ready   = !rst && (state_q == ST_LOAD);
        core_step    = !rst && (state_q == ST_EXEC) && !halt;
        result_valid = !rst && (state_q == ST_DRAIN);
    end

    assign byte_acc = byte_valid && byte_ready;
    assign res_acc  = result_valid && result_ready;

    always_comb begin
        byte_idx_d  = byte_idx_q;
        drain_idx_d = drain_idx_q;
        instr_d     = instr_q;
        buf_d       = buf_q;
        retired_d   = retired_q;

        if (byte_acc) begin
            instr_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
            byte_idx_d = byte_idx_q + 2'd1;
        end

        // The core sees instr combinationally, so its result is valid on the step edge.
        if (core_step) begin
            buf_d     = alu_result;
            retired_d = retired_q + CNT_W'(1);
        end

        if (res_acc) begin
            drain_idx_d = (drain_idx_q == LAST_DRAIN) ? 2'd0 : drain_idx_q + 2'd1;
        end
    end

    assign instr       = instr_q;
    assign result_byte = buf_q[{drain_idx_q, 3'b000} +: 8];
    assign retired     = retired_q;

endmodule

// File: tb/tb_core_byte_sequencer.sv
// Directed bench for core_byte_sequencer: default build plus a 1-byte / 2-bit-counter build.
module tb_core_byte_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (OUT_BYTES=4, CNT_W=8)
    logic        rst, byte_valid, byte_ready, halt, core_step, result_valid, result_ready;
    logic [7:0]  byte_in, result_byte;
    logic [31:0] instr, alu_result;
    logic [7:0]  retired;

    // Narrow instance (OUT_BYTES=1, CNT_W=2)
    logic        rst1, byte_valid1, byte_ready1, halt1, core_step1, result_valid1, result_ready1;
    logic [7:0]  byte_in1, result_byte1;
    logic [31:0] instr1, alu_result1;
    logic [1:0]  retired1;

    // Stand-in ALU: addi rd,x0,imm yields the sign-extended immediate.
    assign alu_result  = {{20{instr[31]}}, instr[31:20]};
    assign alu_result1 = {{20{instr1[31]}}, instr1[31:20]};

    core_byte_sequencer u_dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .halt(halt), .instr(instr), .core_step(core_step),
        .alu_result(alu_result), .result_byte(result_byte), .result_valid(result_valid),
        .result_ready(result_ready), .retired(retired)
    );

    core_byte_sequencer #(.OUT_BYTES(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst1), .byte_in(byte_in1), .byte_valid(byte_valid1),
        .byte_ready(byte_ready1), .halt(halt1), .instr(instr1), .core_step(core_step1),
        .alu_result(alu_result1), .result_byte(result_byte1), .result_valid(result_valid1),
        .result_ready(result_ready1), .retired(retired1)
    );

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    always @(negedge clk) if (core_step) step_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in    = 8'hEE;
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        chk("load_ready", {31'd0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic drain(input logic [31:0] exp, input int stall);
        for (int j = 0; j < 4; j++) begin
            result_ready = 1'b0;
            repeat (stall) begin
                chk("drain_stall_valid", {31'd0, result_valid}, 32'd1);
                chk("drain_stall_byte", {24'd0, result_byte}, {24'd0, exp[8*j +: 8]});
                tick();
            end
            chk("drain_byte", {24'd0, result_byte}, {24'd0, exp[8*j +: 8]});
            result_ready = 1'b1;
            tick();
        end
        result_ready = 1'b0;
    endtask

    logic [31:0] w1 [5];
    logic [7:0]  e1 [5];
    logic [1:0]  r1 [5];
    logic [31:0] w;
    int          s0;
    int          n;

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; halt = 1'b0; result_ready = 1'b0;
        rst1 = 1'b1; byte_valid1 = 1'b0; byte_in1 = 8'h00; halt1 = 1'b0; result_ready1 = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_core_step", {31'd0, core_step}, 32'd0);
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", {31'd0, byte_ready}, 32'd1);
        chk("rst_instr", instr, 32'd0);
        chk("rst_retired", {24'd0, retired}, 32'd0);
        chk("rst_result_byte", {24'd0, result_byte}, 32'd0);

        // 1: back-to-back load, then junk on byte_in during EXEC/DRAIN
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_step", {31'd0, core_step}, 32'd1);
        chk("t1_exec_ready", {31'd0, byte_ready}, 32'd0);
        chk("t1_exec_valid", {31'd0, result_valid}, 32'd0);
        tick();
        byte_in = 8'hBB;
        chk("t1_step_off", {31'd0, core_step}, 32'd0);
        chk("t1_valid", {31'd0, result_valid}, 32'd1);
        chk("t1_retired", {24'd0, retired}, 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk("t1_res_byte", {24'd0, result_byte}, {24'd0, 8'h05 & {8{j == 0}}});
            chk("t1_instr_hold", instr, 32'h0050_0093);
            byte_in = 8'hC0 + 8'(j);
            result_ready = 1'b1;
            tick();
        end
        result_ready = 1'b0;
        byte_valid   = 1'b0;
        chk("t1_instr_final", instr, 32'h0050_0093);
        chk("t1_ready_back", {31'd0, byte_ready}, 32'd1);
        chk("t1_valid_off", {31'd0, result_valid}, 32'd0);

        // 2: gaps in byte stream, 3-cycle stall on every result byte
        s0 = step_cnt;
        send_byte(8'h93, 2);
        send_byte(8'h00, 1);
        send_byte(8'h50, 3);
        send_byte(8'h00, 2);
        chk("t2_instr", instr, 32'h0050_0093);
        tick();
        drain(32'h0000_0005, 3);
        chk("t2_steps", step_cnt - s0, 32'd1);
        chk("t2_retired", {24'd0, retired}, 32'd2);
        chk("t2_ready_back", {31'd0, byte_ready}, 32'd1);

        // 3: halt raised before the last byte, held 5 cycles in EXEC
        s0 = step_cnt;
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        halt = 1'b1;
        send_byte(8'h00, 0);
        repeat (5) begin
            chk("t3_halt_step", {31'd0, core_step}, 32'd0);
            chk("t3_halt_valid", {31'd0, result_valid}, 32'd0);
            tick();
        end
        halt = 1'b0;
        #1;
        chk("t3_step", {31'd0, core_step}, 32'd1);
        tick();
        chk("t3_valid", {31'd0, result_valid}, 32'd1);
        drain(32'h0000_0005, 0);
        chk("t3_steps", step_cnt - s0, 32'd1);
        chk("t3_retired", {24'd0, retired}, 32'd3);

        // 4: reset after two result bytes of an in-flight drain
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        tick();
        result_ready = 1'b1;
        tick();
        tick();
        result_ready = 1'b0;
        chk("t4_pre_valid", {31'd0, result_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t4_valid", {31'd0, result_valid}, 32'd0);
        chk("t4_instr", instr, 32'd0);
        chk("t4_retired", {24'd0, retired}, 32'd0);
        chk("t4_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'hF0, 0);
        send_byte(8'hFF, 0);
        chk("t4_new_instr", instr, 32'hFFF0_0093);
        tick();
        drain(32'hFFFF_FFFF, 1);
        chk("t4_new_retired", {24'd0, retired}, 32'd1);

        // 5: single result byte per instruction, 2-bit retired counter wraps
        w1[0] = 32'h0110_0093; e1[0] = 8'h11; r1[0] = 2'd1;
        w1[1] = 32'h0220_0093; e1[1] = 8'h22; r1[1] = 2'd2;
        w1[2] = 32'h7FF0_0093; e1[2] = 8'hFF; r1[2] = 2'd3;
        w1[3] = 32'h0440_0093; e1[3] = 8'h44; r1[3] = 2'd0;
        w1[4] = 32'h0550_0093; e1[4] = 8'h55; r1[4] = 2'd1;
        rst1 = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            w = w1[i];
            for (int k = 0; k < 4; k++) begin
                byte_valid1 = 1'b1;
                byte_in1    = w[8*k +: 8];
                n = 0;
                while (!byte_ready1 && n < 20) begin
                    tick();
                    n++;
                end
                chk("t5_ready", {31'd0, byte_ready1}, 32'd1);
                tick();
            end
            byte_valid1 = 1'b0;
            chk("t5_instr", instr1, w);
            chk("t5_step", {31'd0, core_step1}, 32'd1);
            tick();
            chk("t5_valid", {31'd0, result_valid1}, 32'd1);
            chk("t5_byte", {24'd0, result_byte1}, {24'd0, e1[i]});
            chk("t5_retired", {30'd0, retired1}, {30'd0, r1[i]});
            result_ready1 = 1'b1;
            tick();
            result_ready1 = 1'b0;
            chk("t5_valid_off", {31'd0, result_valid1}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_byte_sequencer.md
# core_byte_sequencer

Byte-serial sequencer for the single-cycle RV32 datapath on the 8-bit Tiny Tapeout pin interface. It assembles 32-bit instructions from a byte stream and presents each one to the core for exactly one clock-enabled step. It then captures the ALU result and streams it back out byte by byte with a valid/ready handshake. It sits between the top-level pin wrapper and `single_cycle_datapath`, and owns the core's step enable.

## Interface
Parameters:
- OUT_BYTES, 4, number of result bytes drained per instruction (legal 1..4), LSB first
- CNT_W, 8, width of the retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- byte_in  in  8  instruction byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  sequencer accepts a byte this cycle
- halt  in  1  defers execution while high
- instr  out  32  instruction word to the core
- core_step  out  1  clock enable for core PC/register-file update
- alu_result  in  32  core ALU result (combinational from instr)
- result_byte  out  8  result byte
- result_valid  out  1  result_byte valid
- result_ready  in  1  downstream accepts result_byte
- retired  out  CNT_W  count of executed instructions, wraps modulo 2^CNT_W

## Operation
- FSM states: LOAD, EXEC, DRAIN.
- LOAD:
  - byte_ready = 1 (forced 0 while rst).
  - A byte is accepted on byte_valid & byte_ready. Byte k (k = 0..3) is written to instr[8k+7:8k], little-endian.
  - A 2-bit byte index advances on each accept.
  - Accepting byte 3 moves the FSM to EXEC and clears the index to 0.
- EXEC:
  - byte_ready = 0. instr is held stable.
  - If halt = 0: core_step = 1 for this cycle only. alu_result is registered into the result buffer on the same edge, retired increments, and the FSM moves to DRAIN.
  - If halt = 1: core_step = 0 and the FSM stays in EXEC.
- DRAIN:
  - result_valid = 1. result_byte = buffer[8j+7:8j], where j is the drain index.
  - On result_valid & result_ready, j advances.
  - Accepting byte OUT_BYTES-1 moves the FSM to LOAD and clears j to 0.
- instr changes only in LOAD. core_step is never asserted outside EXEC. Only one instruction is in flight; there is no overlap of load and drain.
- Reset values:
  - FSM state LOAD, both indices 0.
  - instr = 0. Opcode 0 decodes as a no-write NOP in the core.
  - core_step = 0, result_valid = 0, result_byte = 0, retired = 0, buffer = 0.
- Reset mid-operation (any state): all of the above on the next edge. Partially loaded bytes are discarded. A pending drain is abandoned.

## Timing
- core_step, result_valid and byte_ready are combinational from state (plus halt, rst). All datapath registers update on the rising clk edge.
- Latency, with halt = 0 and backpressure-free inputs:
  - Byte 3 accepted at edge N. EXEC runs during cycle N..N+1; core_step is high in that cycle. The result is captured at edge N+1.
  - result_valid rises after edge N+1. The first result byte is available in the cycle following EXEC.
  - The last result byte is accepted at edge N+1+OUT_BYTES. byte_ready rises in the following cycle.
- Throughput: 4 + 1 + OUT_BYTES cycles per instruction at best.
- result_byte is stable while result_valid & !result_ready.
- byte_valid during EXEC or DRAIN is ignored; nothing is accepted.
- halt asserted in LOAD or DRAIN has no effect. It is only sampled in EXEC.
- retired wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Reset, then bytes 93 00 50 00 (addi x1,x0,5 = 0x00500093) with valid held high -> instr = 0x00500093, a single-cycle core_step one cycle after the 4th accept, then result bytes 05 00 00 00, retired = 1, then byte_ready = 1.
- Same stream with byte_valid gaps, and result_ready low for 3 cycles on each result byte -> identical instr and result bytes; result_byte held stable while stalled; exactly one core_step.
- halt = 1 before the 4th byte, released after 5 cycles -> core_step stays 0 during halt and pulses once in the cycle halt falls; result is unchanged.
- rst asserted during DRAIN after 2 result bytes -> next cycle: result_valid = 0, instr = 0, retired = 0, byte_ready = 1. A fresh 4-byte load executes normally.
- OUT_BYTES = 1, CNT_W = 2, five instructions -> one result byte each; retired sequence 1, 2, 3, 0, 1.
- byte_valid held high with changing data during EXEC/DRAIN -> instr unchanged until the FSM returns to LOAD.
